// File: rtl/div_pkg.sv
// Shared constants for the two-requester shared divider: FSM encoding and sizing.
// Latency: n/a (package).  Backpressure: n/a (package).
package div_pkg;
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] SUB   = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam int DEF_WIDTH = 4;
    localparam int NUM_REQ   = 2;
endpackage

// File: rtl/div_datapath.sv
// Restoring-division datapath: A (WIDTH+1), Q and D registers with shift and subtract-restore steps.
// Latency: one step per asserted control.  Backpressure: none, steps only when told.
module div_datapath
    import div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_resetn,
    input  logic             i_ld,
    input  logic             i_shift,
    input  logic             i_sub,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_q,
    output logic [WIDTH-1:0] o_a,
    output logic             o_d_zero
);
    logic [WIDTH:0]   r_a;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_d;
    logic [WIDTH:0]   w_diff;
    logic             w_neg;
    logic [WIDTH:0]   w_a_sub;
    logic [WIDTH-1:0] w_q_sub;

    always_comb begin
        w_diff  = r_a - {1'b0, r_d};
        w_neg   = w_diff[WIDTH];
        w_a_sub = w_neg ? r_a : w_diff;
        w_q_sub = {r_q[WIDTH-1:1], ~w_neg};
    end

    // Outputs show the values the pending subtract-restore step would commit, so the
    // controller can capture the final result on the same edge that finishes the last step.
    assign o_q      = w_q_sub;
    assign o_a      = w_a_sub[WIDTH-1:0];
    assign o_d_zero = (r_d == '0);

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_a <= '0;
            r_q <= '0;
            r_d <= '0;
        end else if (i_ld) begin
            r_a <= '0;
            r_q <= i_dividend;
            r_d <= i_divisor;
        end else if (i_shift) begin
            r_a <= {r_a[WIDTH-1:0], r_q[WIDTH-1]};
            r_q <= {r_q[WIDTH-2:0], 1'b0};
        end else if (i_sub) begin
            r_a <= w_a_sub;
            r_q <= w_q_sub;
        end
    end
endmodule

// File: rtl/div_share_ctrl.sv
// Round-robin shares one restoring divider between two requesters; result tagged with requester id.
// Latency: ack in cycle k, done in k+2*WIDTH.  Backpressure: requests held while busy, arbitrated on return to IDLE.
module div_share_ctrl
    import div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic               i_clk,
    input  logic               i_resetn,
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [WIDTH-1:0]   i_dividend0,
    input  logic [WIDTH-1:0]   i_divisor0,
    input  logic [WIDTH-1:0]   i_dividend1,
    input  logic [WIDTH-1:0]   i_divisor1,
    output logic [NUM_REQ-1:0] o_ack,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_done_id,
    output logic [WIDTH-1:0]   o_quotient,
    output logic [WIDTH-1:0]   o_remainder,
    output logic               o_div_zero
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic             r_last_grant;
    logic             r_grant_id;
    logic             r_done_id;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_div_zero;

    logic             w_win_id;
    logic             w_ld;
    logic             w_shift;
    logic             w_sub;
    logic             w_last_iter;
    logic [WIDTH-1:0] w_dividend;
    logic [WIDTH-1:0] w_divisor;
    logic [WIDTH-1:0] w_q_res;
    logic [WIDTH-1:0] w_a_res;
    logic             w_d_zero;

    // On a tie the requester that did not win last time goes first.
    always_comb begin
        w_win_id = 1'b0;
        case (i_req)
            2'b10:   w_win_id = 1'b1;
            2'b11:   w_win_id = ~r_last_grant;
            default: w_win_id = 1'b0;
        endcase
    end

    assign w_ld        = (r_state == IDLE) && (|i_req);
    assign w_last_iter = (r_state == SUB) && (r_cnt == CNT_LAST);
    assign w_dividend  = w_win_id ? i_dividend1 : i_dividend0;
    assign w_divisor   = w_win_id ? i_divisor1  : i_divisor0;

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) r_state <= IDLE;
        else           r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (|i_req) w_state_nxt = SHIFT;
            SHIFT:   w_state_nxt = SUB;
            SUB:     w_state_nxt = w_last_iter ? DONE : SHIFT;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // The first SHIFT (cnt still 0) is exactly the cycle after the grant edge.
    always_comb begin
        o_ack = '0;
        if ((r_state == SHIFT) && (r_cnt == '0)) o_ack[r_grant_id] = 1'b1;
        o_busy  = (r_state != IDLE);
        o_done  = (r_state == DONE);
        w_shift = (r_state == SHIFT);
        w_sub   = (r_state == SUB);
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_cnt        <= '0;
            r_last_grant <= 1'b1;
            r_grant_id   <= 1'b0;
            r_done_id    <= 1'b0;
            r_quotient   <= '0;
            r_remainder  <= '0;
            r_div_zero   <= 1'b0;
        end else begin
            if (w_ld) begin
                r_cnt        <= '0;
                r_grant_id   <= w_win_id;
                r_last_grant <= w_win_id;
            end else if (w_sub && !w_last_iter) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_last_iter) begin
                r_quotient  <= w_q_res;
                r_remainder <= w_a_res;
                r_div_zero  <= w_d_zero;
                r_done_id   <= r_grant_id;
            end
        end
    end

    assign o_done_id   = r_done_id;
    assign o_quotient  = r_quotient;
    assign o_remainder = r_remainder;
    assign o_div_zero  = r_div_zero;

    div_datapath #(.WIDTH(WIDTH)) u_datapath (
        .i_clk      (i_clk),
        .i_resetn   (i_resetn),
        .i_ld       (w_ld),
        .i_shift    (w_shift),
        .i_sub      (w_sub),
        .i_dividend (w_dividend),
        .i_divisor  (w_divisor),
        .o_q        (w_q_res),
        .o_a        (w_a_res),
        .o_d_zero   (w_d_zero)
    );
endmodule

// File: tb/tb_div_share_ctrl.sv
// Directed bench for div_share_ctrl at WIDTH=4 with hand-computed results.
module tb_div_share_ctrl;
    localparam int W = 4;

    logic         i_clk = 1'b0;
    logic         i_resetn = 1'b0;
    logic [1:0]   i_req = 2'b00;
    logic [W-1:0] i_dividend0 = '0;
    logic [W-1:0] i_divisor0 = '0;
    logic [W-1:0] i_dividend1 = '0;
    logic [W-1:0] i_divisor1 = '0;
    logic [1:0]   o_ack;
    logic         o_busy;
    logic         o_done;
    logic         o_done_id;
    logic [W-1:0] o_quotient;
    logic [W-1:0] o_remainder;
    logic         o_div_zero;

    int vec = 0;
    int errs = 0;

    always #5 i_clk = ~i_clk;

    div_share_ctrl #(.WIDTH(W)) dut (
        .i_clk       (i_clk),
        .i_resetn    (i_resetn),
        .i_req       (i_req),
        .i_dividend0 (i_dividend0),
        .i_divisor0  (i_divisor0),
        .i_dividend1 (i_dividend1),
        .i_divisor1  (i_divisor1),
        .o_ack       (o_ack),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_done_id   (o_done_id),
        .o_quotient  (o_quotient),
        .o_remainder (o_remainder),
        .o_div_zero  (o_div_zero)
    );

    task automatic test_reset();
        i_resetn = 1'b0;
        i_req    = 2'b00;
        repeat (3) @(negedge i_clk);
        vec++;
        if ({o_ack, o_busy, o_done, o_done_id, o_quotient, o_remainder, o_div_zero} !== '0) begin
            errs++;
            $display("FAIL reset_outputs: got ack=%b busy=%b done=%b id=%b q=%0d r=%0d dz=%b, expected all 0",
                     o_ack, o_busy, o_done, o_done_id, o_quotient, o_remainder, o_div_zero);
        end
        i_resetn = 1'b1;
        @(negedge i_clk);
        vec++;
        if ({o_ack, o_busy} !== 3'b000) begin
            errs++;
            $display("FAIL idle_after_reset: got ack=%b busy=%b, expected 00/0", o_ack, o_busy);
        end
    endtask

    task automatic test_basic();
        i_req = 2'b01; i_dividend0 = 4'd13; i_divisor0 = 4'd4;
        @(negedge i_clk);
        vec++;
        if (o_ack !== 2'b01 || o_busy !== 1'b1) begin
            errs++;
            $display("FAIL basic_ack: got ack=%b busy=%b, expected 01/1", o_ack, o_busy);
        end
        i_req = 2'b00;
        for (int c = 1; c <= 9; c++) begin
            @(negedge i_clk);
            if (c == 7) begin
                vec++;
                if (o_done !== 1'b0 || o_quotient !== 4'd0 || o_busy !== 1'b1) begin
                    errs++;
                    $display("FAIL basic_pre_done: got done=%b q=%0d busy=%b, expected 0/0/1", o_done, o_quotient, o_busy);
                end
            end
            if (c == 8) begin
                vec++;
                if (o_done !== 1'b1 || o_quotient !== 4'd3 || o_remainder !== 4'd1 ||
                    o_div_zero !== 1'b0 || o_done_id !== 1'b0 || o_busy !== 1'b1) begin
                    errs++;
                    $display("FAIL basic_result: got done=%b q=%0d r=%0d dz=%b id=%b busy=%b, expected 1/3/1/0/0/1",
                             o_done, o_quotient, o_remainder, o_div_zero, o_done_id, o_busy);
                end
            end
            if (c == 9) begin
                vec++;
                if (o_done !== 1'b0 || o_busy !== 1'b0 || o_quotient !== 4'd3) begin
                    errs++;
                    $display("FAIL basic_post_done: got done=%b busy=%b q=%0d, expected 0/0/3", o_done, o_busy, o_quotient);
                end
            end
        end
    endtask

    task automatic test_less();
        i_req = 2'b10; i_dividend1 = 4'd7; i_divisor1 = 4'd9;
        @(negedge i_clk);
        vec++;
        if (o_ack !== 2'b10) begin
            errs++;
            $display("FAIL less_ack: got %b expected 10", o_ack);
        end
        i_req = 2'b00;
        repeat (8) @(negedge i_clk);
        vec++;
        if (o_done !== 1'b1 || o_quotient !== 4'd0 || o_remainder !== 4'd7 ||
            o_div_zero !== 1'b0 || o_done_id !== 1'b1) begin
            errs++;
            $display("FAIL less_result: got done=%b q=%0d r=%0d dz=%b id=%b, expected 1/0/7/0/1",
                     o_done, o_quotient, o_remainder, o_div_zero, o_done_id);
        end
        @(negedge i_clk);
    endtask

    task automatic test_divzero();
        i_req = 2'b01; i_dividend0 = 4'd15; i_divisor0 = 4'd0;
        @(negedge i_clk);
        vec++;
        if (o_ack !== 2'b01) begin
            errs++;
            $display("FAIL dz_ack: got %b expected 01", o_ack);
        end
        i_req = 2'b00;
        repeat (8) @(negedge i_clk);
        vec++;
        if (o_done !== 1'b1 || o_quotient !== 4'd15 || o_remainder !== 4'd15 ||
            o_div_zero !== 1'b1 || o_done_id !== 1'b0) begin
            errs++;
            $display("FAIL dz_result: got done=%b q=%0d r=%0d dz=%b id=%b, expected 1/15/15/1/0",
                     o_done, o_quotient, o_remainder, o_div_zero, o_done_id);
        end
        @(negedge i_clk);
    endtask

    task automatic test_tie();
        i_resetn = 1'b0;
        @(negedge i_clk);
        i_resetn = 1'b1;
        @(negedge i_clk);
        i_req = 2'b11;
        i_dividend0 = 4'd10; i_divisor0 = 4'd3;
        i_dividend1 = 4'd14; i_divisor1 = 4'd5;
        @(negedge i_clk);
        vec++;
        if (o_ack !== 2'b01) begin
            errs++;
            $display("FAIL tie_first_ack: got %b expected 01", o_ack);
        end
        i_req = 2'b10;
        for (int c = 1; c <= 18; c++) begin
            @(negedge i_clk);
            if (c == 8) begin
                vec++;
                if (o_done !== 1'b1 || o_quotient !== 4'd3 || o_remainder !== 4'd1 || o_done_id !== 1'b0) begin
                    errs++;
                    $display("FAIL tie_result0: got done=%b q=%0d r=%0d id=%b, expected 1/3/1/0",
                             o_done, o_quotient, o_remainder, o_done_id);
                end
            end
            if (c == 9) begin
                vec++;
                if (o_ack !== 2'b00) begin
                    errs++;
                    $display("FAIL tie_early_ack: got %b expected 00", o_ack);
                end
            end
            if (c == 10) begin
                vec++;
                if (o_ack !== 2'b10) begin
                    errs++;
                    $display("FAIL tie_second_ack: got %b expected 10", o_ack);
                end
                i_req = 2'b00;
            end
            if (c == 18) begin
                vec++;
                if (o_done !== 1'b1 || o_quotient !== 4'd2 || o_remainder !== 4'd4 || o_done_id !== 1'b1) begin
                    errs++;
                    $display("FAIL tie_result1: got done=%b q=%0d r=%0d id=%b, expected 1/2/4/1",
                             o_done, o_quotient, o_remainder, o_done_id);
                end
            end
        end
        @(negedge i_clk);
    endtask

    task automatic test_busy_req();
        int bad_acks = 0;
        i_req = 2'b01; i_dividend0 = 4'd9; i_divisor0 = 4'd3;
        @(negedge i_clk);
        vec++;
        if (o_ack !== 2'b01) begin
            errs++;
            $display("FAIL busy_first_ack: got %b expected 01", o_ack);
        end
        i_req = 2'b00;
        for (int c = 1; c <= 18; c++) begin
            @(negedge i_clk);
            if (c < 10 && o_ack !== 2'b00) bad_acks++;
            if (c == 1) begin
                i_req = 2'b10; i_dividend1 = 4'd12; i_divisor1 = 4'd5;
            end
            if (c == 8) begin
                vec++;
                if (o_done !== 1'b1 || o_quotient !== 4'd3 || o_remainder !== 4'd0 || o_done_id !== 1'b0) begin
                    errs++;
                    $display("FAIL busy_result0: got done=%b q=%0d r=%0d id=%b, expected 1/3/0/0",
                             o_done, o_quotient, o_remainder, o_done_id);
                end
            end
            if (c == 10) begin
                vec++;
                if (bad_acks != 0 || o_ack !== 2'b10) begin
                    errs++;
                    $display("FAIL busy_deferred_ack: got ack=%b early_acks=%0d, expected 10/0", o_ack, bad_acks);
                end
                i_req = 2'b00;
            end
            if (c == 18) begin
                vec++;
                if (o_done !== 1'b1 || o_quotient !== 4'd2 || o_remainder !== 4'd2 || o_done_id !== 1'b1) begin
                    errs++;
                    $display("FAIL busy_result1: got done=%b q=%0d r=%0d id=%b, expected 1/2/2/1",
                             o_done, o_quotient, o_remainder, o_done_id);
                end
            end
        end
        @(negedge i_clk);
    endtask

    task automatic test_reset_mid();
        int spurious = 0;
        i_req = 2'b01; i_dividend0 = 4'd13; i_divisor0 = 4'd4;
        @(negedge i_clk);
        i_req = 2'b00;
        repeat (5) @(negedge i_clk);
        // Now in the third SUB cycle; pull reset between clock edges.
        #1 i_resetn = 1'b0;
        #1;
        vec++;
        if ({o_ack, o_busy, o_done, o_done_id, o_quotient, o_remainder, o_div_zero} !== '0) begin
            errs++;
            $display("FAIL midreset_outputs: got ack=%b busy=%b done=%b id=%b q=%0d r=%0d dz=%b, expected all 0",
                     o_ack, o_busy, o_done, o_done_id, o_quotient, o_remainder, o_div_zero);
        end
        repeat (2) @(negedge i_clk);
        i_resetn = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge i_clk);
            if (o_done !== 1'b0 || o_busy !== 1'b0) spurious++;
        end
        vec++;
        if (spurious != 0) begin
            errs++;
            $display("FAIL midreset_no_done: got %0d active cycles, expected 0", spurious);
        end
        i_req = 2'b01; i_dividend0 = 4'd9; i_divisor0 = 4'd2;
        @(negedge i_clk);
        vec++;
        if (o_ack !== 2'b01) begin
            errs++;
            $display("FAIL midreset_ack: got %b expected 01", o_ack);
        end
        i_req = 2'b00;
        repeat (8) @(negedge i_clk);
        vec++;
        if (o_done !== 1'b1 || o_quotient !== 4'd4 || o_remainder !== 4'd1 || o_div_zero !== 1'b0) begin
            errs++;
            $display("FAIL midreset_result: got done=%b q=%0d r=%0d dz=%b, expected 1/4/1/0",
                     o_done, o_quotient, o_remainder, o_div_zero);
        end
        @(negedge i_clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_less();
        test_divzero();
        test_tie();
        test_busy_req();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
